// File: rtl/interrupt_scan_scheduler.sv
// Walks the enabled interrupt lines through one shared checker: select, settle, start, handshake, observe, capture.
// DONE follows RUN by 1 + per-channel cost; RUN is ignored while BUSY, ABORT returns to IDLE from any state.
module interrupt_scan_scheduler #(
   parameter int SEL_W  = 2,
   parameter int WIN_W  = 16,
   parameter int SETTLE = 4,
   parameter int ARM_TO = 3
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  RUN,
   input  logic                  ABORT,
   input  logic [2**SEL_W-1:0]   CH_ENABLE,
   input  logic [WIN_W-1:0]      WINDOW,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [SEL_W-1:0]      CHK_SEL,
   output logic                  CHK_START,
   input  logic                  CHK_BUSY,
   input  logic                  CHK_INIT_STATE,
   input  logic                  CHK_TRANSITION,
   output logic [2**SEL_W-1:0]   INIT_STATES,
   output logic [2**SEL_W-1:0]   TRANSITIONS,
   output logic [2**SEL_W-1:0]   ERR_CH
);
   localparam int N_CH = 2**SEL_W;

   typedef enum logic [2:0] {IDLE, SELECT, START, ARM_HI, ARM_LO, OBSERVE, CAPTURE, FINISH} state_t;

   state_t            state, state_d;
   logic [WIN_W-1:0]  cnt, cnt_d;
   logic [SEL_W-1:0]  ch, ch_d;
   logic [N_CH-1:0]   en_q;
   logic [WIN_W-1:0]  win_q;
   logic              start_q;
   logic              latch, cap, err_set, adv;
   logic              lo_found, nx_found;
   logic [SEL_W-1:0]  lo_idx, nx_idx;

   // ABORT must kill a start pulse already on the wire this cycle.
   assign CHK_START = start_q & ~ABORT;

   always_comb begin
      lo_found = 1'b0;
      lo_idx   = '0;
      nx_found = 1'b0;
      nx_idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (CH_ENABLE[i]) begin
            lo_found = 1'b1;
            lo_idx   = SEL_W'(i);
         end
         if (en_q[i] && (i > int'(ch))) begin
            nx_found = 1'b1;
            nx_idx   = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      ch_d    = ch;
      latch   = 1'b0;
      cap     = 1'b0;
      err_set = 1'b0;
      adv     = 1'b0;
      case (state)
         IDLE: begin
            if (RUN) begin
               latch   = 1'b1;
               ch_d    = lo_idx;
               cnt_d   = '0;
               state_d = lo_found ? SELECT : FINISH;
            end
         end
         SELECT: begin
            if (cnt == WIN_W'(SETTLE - 1)) begin
               state_d = START;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + WIN_W'(1);
            end
         end
         START: begin
            state_d = ARM_HI;
            cnt_d   = '0;
         end
         ARM_HI: begin
            if (CHK_BUSY) begin
               state_d = ARM_LO;
               cnt_d   = '0;
            end else if (cnt == WIN_W'(ARM_TO - 1)) begin
               err_set = 1'b1;
               adv     = 1'b1;
            end else begin
               cnt_d = cnt + WIN_W'(1);
            end
         end
         ARM_LO: begin
            if (!CHK_BUSY) begin
               state_d = (win_q == '0) ? CAPTURE : OBSERVE;
               cnt_d   = '0;
            end else if (cnt == WIN_W'(ARM_TO - 1)) begin
               err_set = 1'b1;
               adv     = 1'b1;
            end else begin
               cnt_d = cnt + WIN_W'(1);
            end
         end
         OBSERVE: begin
            if (cnt == win_q - WIN_W'(1)) begin
               state_d = CAPTURE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + WIN_W'(1);
            end
         end
         CAPTURE: begin
            cap = 1'b1;
            adv = 1'b1;
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (adv) begin
         cnt_d = '0;
         if (nx_found) begin
            state_d = SELECT;
            ch_d    = nx_idx;
         end else begin
            state_d = FINISH;
         end
      end

      if (ABORT) begin
         state_d = IDLE;
         cnt_d   = '0;
         ch_d    = ch;
         latch   = 1'b0;
         cap     = 1'b0;
         err_set = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         cnt         <= '0;
         ch          <= '0;
         en_q        <= '0;
         win_q       <= '0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         start_q     <= 1'b0;
         CHK_SEL     <= '0;
         INIT_STATES <= '0;
         TRANSITIONS <= '0;
         ERR_CH      <= '0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         ch      <= ch_d;
         BUSY    <= (state_d != IDLE);
         DONE    <= (state_d == FINISH);
         start_q <= (state_d == START);
         if (state_d == SELECT && state != SELECT)
            CHK_SEL <= ch_d;
         if (latch) begin
            en_q        <= CH_ENABLE;
            win_q       <= WINDOW;
            INIT_STATES <= '0;
            TRANSITIONS <= '0;
            ERR_CH      <= '0;
         end
         if (cap) begin
            INIT_STATES[ch] <= CHK_INIT_STATE;
            TRANSITIONS[ch] <= CHK_TRANSITION;
         end
         if (err_set)
            ERR_CH[ch] <= 1'b1;
      end
   end
endmodule

// File: tb/tb_interrupt_scan_scheduler.sv
// Bench for interrupt_scan_scheduler: table vectors, hand sequences for abort/reset/edge, and random scans vs a cycle-cost model.
module tb_interrupt_scan_scheduler;
   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        RUN = 1'b0;
   logic        ABORT = 1'b0;
   logic [3:0]  CH_ENABLE = '0;
   logic [15:0] WINDOW = '0;
   logic        BUSY, DONE, CHK_START;
   logic [1:0]  CHK_SEL;
   logic        CHK_BUSY = 1'b0;
   logic        CHK_INIT_STATE = 1'b0;
   logic        CHK_TRANSITION = 1'b0;
   logic [3:0]  INIT_STATES, TRANSITIONS, ERR_CH;

   interrupt_scan_scheduler dut (
      .CLK(CLK), .RST_N(RST_N), .RUN(RUN), .ABORT(ABORT),
      .CH_ENABLE(CH_ENABLE), .WINDOW(WINDOW),
      .BUSY(BUSY), .DONE(DONE), .CHK_SEL(CHK_SEL), .CHK_START(CHK_START),
      .CHK_BUSY(CHK_BUSY), .CHK_INIT_STATE(CHK_INIT_STATE), .CHK_TRANSITION(CHK_TRANSITION),
      .INIT_STATES(INIT_STATES), .TRANSITIONS(TRANSITIONS), .ERR_CH(ERR_CH)
   );

   always #5 CLK = ~CLK;

   localparam int SETTLE = 4;
   localparam int ARM_TO = 3;

   int         vecs = 0;
   int         errs = 0;
   logic [3:0] lines = '0;
   logic [3:0] dead = '0;
   int         fall_k = -1;
   int         fall_ch = 0;
   logic [1:0] sel_log [8];

   // Checker stand-in: busy for three sampled edges after START, latches the
   // line level at START and flags any falling edge afterwards.
   int   bcnt = 0;
   logic prev = 1'b0;
   always @(negedge CLK) begin
      #2;
      if (!RST_N) begin
         bcnt = 0;
         CHK_INIT_STATE = 1'b0;
         CHK_TRANSITION = 1'b0;
         prev = 1'b0;
      end else if (CHK_START && !dead[CHK_SEL]) begin
         bcnt = 3;
         CHK_INIT_STATE = lines[CHK_SEL];
         CHK_TRANSITION = 1'b0;
         prev = lines[CHK_SEL];
      end else begin
         if (bcnt > 0) bcnt--;
         if (prev && !lines[CHK_SEL]) CHK_TRANSITION = 1'b1;
         prev = lines[CHK_SEL];
      end
      CHK_BUSY = (bcnt > 0);
   end

   task automatic chk(input string nm, input int act, input int exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference cost of a whole scan: one cycle for FINISH plus each enabled channel.
   function automatic int ref_cycles(input logic [3:0] en, input int win, input logic [3:0] dd);
      int c = 1;
      for (int i = 0; i < 4; i++)
         if (en[i]) c += dd[i] ? (SETTLE + 1 + ARM_TO) : (SETTLE + win + 5);
      return c;
   endfunction

   task automatic run_scan(input string tag, input logic [3:0] en, input logic [15:0] win,
                           input int exp_k, input logic [3:0] ei, input logic [3:0] et,
                           input logic [3:0] ee, input int poke);
      int k = 0;
      int starts = 0;
      int done_k = -1;
      int busy_low = 0;
      @(negedge CLK);
      RUN = 1'b1;
      CH_ENABLE = en;
      WINDOW = win;
      while (done_k < 0 && k < 3000) begin
         @(negedge CLK);
         k++;
         RUN = (k == poke);
         if (k == poke) begin
            CH_ENABLE = 4'($urandom);
            WINDOW = 16'($urandom);
         end
         if (k == fall_k) lines[fall_ch] = 1'b0;
         if (CHK_START) begin
            if (starts < 8) sel_log[starts] = CHK_SEL;
            starts++;
         end
         if (!BUSY) busy_low++;
         if (DONE) done_k = k;
      end
      RUN = 1'b0;
      chk({tag, " done_cycle"}, done_k, exp_k);
      chk({tag, " busy_gaps"}, busy_low, 0);
      chk({tag, " starts"}, starts, $countones(en));
      chk({tag, " init_states"}, int'(INIT_STATES), int'(ei));
      chk({tag, " transitions"}, int'(TRANSITIONS), int'(et));
      chk({tag, " err_ch"}, int'(ERR_CH), int'(ee));
      @(negedge CLK);
      chk({tag, " idle_after"}, int'({BUSY, DONE}), 0);
   endtask

   typedef struct {
      logic [3:0]  en;
      logic [15:0] win;
      logic [3:0]  ln;
      logic [3:0]  dd;
      int          cyc;
      logic [3:0]  ei;
      logic [3:0]  et;
      logic [3:0]  ee;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{4'b0001, 16'd10, 4'b1111, 4'b0000, 20, 4'b0001, 4'b0000, 4'b0000};
      tbl[1] = '{4'b0011, 16'd3,  4'b1111, 4'b0011, 17, 4'b0000, 4'b0000, 4'b0011};
      tbl[2] = '{4'b0000, 16'd5,  4'b1111, 4'b0000, 1,  4'b0000, 4'b0000, 4'b0000};
      tbl[3] = '{4'b0001, 16'd0,  4'b1111, 4'b0000, 10, 4'b0001, 4'b0000, 4'b0000};
      tbl[4] = '{4'b1111, 16'd2,  4'b0101, 4'b0100, 42, 4'b0001, 4'b0000, 4'b0100};
      tbl[5] = '{4'b1000, 16'd1,  4'b1000, 4'b0000, 11, 4'b1000, 4'b0000, 4'b0000};

      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      chk("reset_outputs", int'({BUSY, DONE, CHK_START, CHK_SEL, INIT_STATES, TRANSITIONS, ERR_CH}), 0);

      for (int v = 0; v < 6; v++) begin
         lines = tbl[v].ln;
         dead = tbl[v].dd;
         run_scan($sformatf("tbl%0d", v), tbl[v].en, tbl[v].win, tbl[v].cyc,
                  tbl[v].ei, tbl[v].et, tbl[v].ee, -1);
      end

      // ch3 falls mid-window, ch1 stays high; a stray RUN mid-scan must not disturb it
      lines = 4'b1010;
      dead = 4'b0000;
      fall_k = 29;
      fall_ch = 3;
      run_scan("edge", 4'b1010, 16'd8, 35, 4'b1010, 4'b1000, 4'b0000, 12);
      fall_k = -1;
      chk("edge sel_first", int'(sel_log[0]), 1);
      chk("edge sel_second", int'(sel_log[1]), 3);

      // abort during ch2 observe, with ABORT and RUN together
      begin
         int saw_done = 0;
         lines = 4'b0011;
         @(negedge CLK);
         RUN = 1'b1;
         CH_ENABLE = 4'b0111;
         WINDOW = 16'd20;
         for (int k = 1; k <= 75; k++) begin
            @(negedge CLK);
            RUN = 1'b0;
            if (DONE) saw_done++;
         end
         chk("abort sel_before", int'(CHK_SEL), 2);
         ABORT = 1'b1;
         RUN = 1'b1;
         @(negedge CLK);
         ABORT = 1'b0;
         RUN = 1'b0;
         chk("abort busy", int'(BUSY), 0);
         repeat (6) begin
            @(negedge CLK);
            if (DONE) saw_done++;
         end
         chk("abort no_done", saw_done, 0);
         chk("abort init_kept", int'(INIT_STATES), 3);
         chk("abort err_kept", int'(ERR_CH), 0);
         ABORT = 1'b1;
         RUN = 1'b1;
         CH_ENABLE = 4'b1111;
         @(negedge CLK);
         ABORT = 1'b0;
         RUN = 1'b0;
         @(negedge CLK);
         chk("abort_run no_start", int'(BUSY), 0);
         chk("abort_run no_clear", int'(INIT_STATES), 3);
      end

      // abort lands on the START cycle: the pulse must drop at once
      @(negedge CLK);
      RUN = 1'b1;
      CH_ENABLE = 4'b0001;
      WINDOW = 16'd3;
      repeat (5) begin
         @(negedge CLK);
         RUN = 1'b0;
      end
      ABORT = 1'b1;
      #1;
      chk("abort_start pulse", int'(CHK_START), 0);
      @(negedge CLK);
      ABORT = 1'b0;
      chk("abort_start busy", int'(BUSY), 0);

      // asynchronous reset while in ARM_LO of ch2
      lines = 4'b0100;
      @(negedge CLK);
      RUN = 1'b1;
      CH_ENABLE = 4'b0100;
      WINDOW = 16'd5;
      repeat (7) begin
         @(negedge CLK);
         RUN = 1'b0;
      end
      chk("rst sel_before", int'({BUSY, CHK_SEL}), 6);
      RST_N = 1'b0;
      #1;
      chk("rst outputs", int'({BUSY, DONE, CHK_START, CHK_SEL, INIT_STATES, TRANSITIONS, ERR_CH}), 0);
      @(negedge CLK);
      RST_N = 1'b1;
      run_scan("post_rst", 4'b0100, 16'd5, 15, 4'b0100, 4'b0000, 4'b0000, -1);

      for (int r = 0; r < 12; r++) begin
         logic [3:0] en, dd;
         int win, ek, pk;
         en = 4'($urandom);
         dd = 4'($urandom) & 4'($urandom);
         win = $urandom_range(0, 6);
         lines = 4'($urandom);
         dead = dd;
         ek = ref_cycles(en, win, dd);
         pk = $urandom_range(2, ek);
         run_scan($sformatf("rnd%0d", r), en, 16'(win), ek,
                  en & ~dd & lines, 4'b0000, en & dd, pk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
